// File: rtl/pc_next_unit.sv
// Program-counter stage for the single-cycle MIPS datapath: holds PC, forms
// PC+4 / branch / jump targets, sequences BOOT/RUN/HALT and counts taken branches.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             halt,
    input  logic             branch,
    input  logic             branch_ne,
    input  logic             zero,
    input  logic [31:0]      offset_sl2,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [31:0]      branch_target,
    output logic             pc_valid,
    output logic             taken,
    output logic [CNT_W-1:0] branch_count,
    output logic             halted
);

    // Low bits are forced clear so a misaligned parameter cannot break alignment.
    localparam logic [31:0]      RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [CNT_W-1:0] CNT_MAX          = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE          = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic             r_taken;
    logic             w_taken_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_pc_valid;
    logic             w_pc_valid_nxt;
    logic             r_halted;
    logic             w_halted_nxt;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_branch_target;
    logic [31:0]      w_jump_target;
    logic             w_br_taken;

    function automatic logic [31:0] jump_addr(input logic [31:0] seq_pc,
                                              input logic [25:0] index);
        jump_addr = {seq_pc[31:28], index, 2'b00};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_ONE;
        end
    endfunction

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + offset_sl2;
    assign w_jump_target   = jump_addr(w_pc_plus4, jump_index);
    assign w_br_taken      = branch & (zero ^ branch_ne);

    // Next-state, next-PC, taken pulse and counter update.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_taken_nxt    = 1'b0;
        w_count_nxt    = r_count;
        w_pc_valid_nxt = r_pc_valid;
        w_halted_nxt   = r_halted;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt    = ST_RUN;
                w_pc_valid_nxt = 1'b1;
                w_halted_nxt   = 1'b0;
            end
            ST_RUN: begin
                if (halt) begin
                    w_state_nxt    = ST_HALT;
                    w_pc_valid_nxt = 1'b0;
                    w_halted_nxt   = 1'b1;
                end else if (en) begin
                    // Jump outranks a simultaneous branch and is not counted.
                    if (jump) begin
                        w_pc_nxt    = w_jump_target;
                        w_taken_nxt = 1'b1;
                    end else if (w_br_taken) begin
                        w_pc_nxt    = w_branch_target;
                        w_taken_nxt = 1'b1;
                        w_count_nxt = sat_inc(r_count);
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            ST_HALT: begin
                w_pc_valid_nxt = 1'b0;
                w_halted_nxt   = 1'b1;
            end
            default: begin
                w_state_nxt    = ST_BOOT;
                w_pc_nxt       = RESET_PC_ALIGNED;
                w_pc_valid_nxt = 1'b0;
                w_halted_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC_ALIGNED;
            r_taken    <= 1'b0;
            r_count    <= {CNT_W{1'b0}};
            r_pc_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_taken    <= w_taken_nxt;
            r_count    <= w_count_nxt;
            r_pc_valid <= w_pc_valid_nxt;
            r_halted   <= w_halted_nxt;
        end
    end

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign branch_target = w_branch_target;
    assign pc_valid      = r_pc_valid;
    assign taken         = r_taken;
    assign branch_count  = r_count;
    assign halted        = r_halted;

endmodule
